// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue unit: ALU op codes, instruction classes,
// funct3 values and FSM state encoding.
package alu_issue_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1010;

  localparam logic [1:0] CLS_MEM = 2'b00;
  localparam logic [1:0] CLS_BR  = 2'b01;
  localparam logic [1:0] CLS_R   = 2'b10;
  localparam logic [1:0] CLS_I   = 2'b11;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of class/funct3/funct7[5] into ALU op code, operand B
// and an illegal flag. Illegal encodings collapse to AND with B=0.
module alu_op_decode
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      cls_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic            illegal_o
);

  always_comb begin
    alu_op_o  = ALU_AND;
    alu_b_o   = '0;
    illegal_o = 1'b0;
    case (cls_i)
      CLS_MEM: begin
        alu_op_o = ALU_ADD;
        alu_b_o  = imm_i;
      end
      CLS_BR: begin
        alu_op_o  = ALU_SUB;
        alu_b_o   = rs2_i;
        illegal_o = (funct3_i != F3_BEQ) && (funct3_i != F3_BNE);
      end
      CLS_R: begin
        alu_b_o = rs2_i;
        case (funct3_i)
          F3_ADD:  alu_op_o = funct7_5_i ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_op_o = ALU_AND;
          F3_OR:   alu_op_o = ALU_OR;
          F3_SRL:  begin
            alu_op_o  = ALU_SRL;
            illegal_o = funct7_5_i;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      default: begin
        alu_b_o = imm_i;
        case (funct3_i)
          F3_ADD:  alu_op_o = ALU_ADD;
          F3_AND:  alu_op_o = ALU_AND;
          F3_OR:   alu_op_o = ALU_OR;
          // Shift immediates only use the shamt field of imm.
          F3_SRL:  begin
            alu_op_o  = ALU_SRL;
            alu_b_o   = {{(XLEN-5){1'b0}}, imm_i[4:0]};
            illegal_o = funct7_5_i;
          end
          default: illegal_o = 1'b1;
        endcase
      end
    endcase
    if (illegal_o) begin
      alu_op_o = ALU_AND;
      alu_b_o  = '0;
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Execute-stage ALU issue unit: IDLE -> EXEC -> DONE FSM around an external ALU.
// Define ALU_ISSUE_BYPASS_EN to allow a new accept in the same cycle as the output handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
// valid must be held with stable payload until that edge, ready may change freely.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_class,
  input  logic [2:0]         in_funct3,
  input  logic               in_funct7_5,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  input  logic [XLEN-1:0]    alu_result,
  input  logic               alu_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic               out_zero,
  output logic               out_branch_taken,
  output logic               out_illegal,
  output logic [1:0]         dbg_state
);

  logic [1:0]         state_q, state_d;
  logic [XLEN-1:0]    alu_a_q, alu_b_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               is_br_q, br_ne_q, illegal_q;
  logic [XLEN-1:0]    out_result_q;
  logic               out_zero_q, out_taken_q, out_illegal_q;

  logic [3:0]         dec_op;
  logic [XLEN-1:0]    dec_b;
  logic               dec_illegal;
  logic               out_hs, accept;

  alu_op_decode #(.XLEN(XLEN)) u_decode (
    .cls_i      (in_class),
    .funct3_i   (in_funct3),
    .funct7_5_i (in_funct7_5),
    .rs2_i      (in_rs2),
    .imm_i      (in_imm),
    .alu_op_o   (dec_op),
    .alu_b_o    (dec_b),
    .illegal_o  (dec_illegal)
  );

  assign out_hs = (state_q == ST_DONE) && out_ready;
`ifdef ALU_ISSUE_BYPASS_EN
  assign in_ready = (state_q == ST_IDLE) || out_hs;
`else
  assign in_ready = (state_q == ST_IDLE);
`endif
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        if (accept)      state_d = ST_EXEC;
        else if (out_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      is_br_q       <= 1'b0;
      br_ne_q       <= 1'b0;
      illegal_q     <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q   <= dec_illegal ? '0 : in_rs1;
        alu_b_q   <= dec_b;
        alu_op_q  <= dec_op;
        is_br_q   <= (in_class == CLS_BR);
        br_ne_q   <= (in_funct3 == F3_BNE);
        illegal_q <= dec_illegal;
      end
      // Legal branches are only BEQ/BNE, so one polarity bit decides taken.
      if (state_q == ST_EXEC) begin
        out_result_q  <= illegal_q ? '0 : alu_result;
        out_zero_q    <= !illegal_q && alu_zero;
        out_taken_q   <= !illegal_q && is_br_q && (br_ne_q ? !alu_zero : alu_zero);
        out_illegal_q <= illegal_q;
      end
    end
  end

  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_op           = alu_op_q;
  assign out_valid        = (state_q == ST_DONE);
  assign out_result       = out_result_q;
  assign out_zero         = out_zero_q;
  assign out_branch_taken = out_taken_q;
  assign out_illegal      = out_illegal_q;
  assign dbg_state        = state_q;

endmodule
